// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type and GF(2^8) helpers
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int COL_W  = 32;
  localparam int N_ROWS = 4;

  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul2(input logic [BYTE_W-1:0] b);
    return xtime(b);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul3(input logic [BYTE_W-1:0] b);
    return xtime(b) ^ b;
  endfunction

  // Higher inverse constants decompose as sums of b, 2b, 4b and 8b.
  function automatic logic [BYTE_W-1:0] gmul9(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul11(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul13(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul14(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mixcol_column.sv
// rtl/mixcol_column.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module mixcol_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  input  logic             i_decrypt,
  output logic [COL_W-1:0] o_col
);

  logic [BYTE_W-1:0] w_b0, w_b1, w_b2, w_b3;
  logic [COL_W-1:0]  w_fwd, w_inv;

  assign {w_b0, w_b1, w_b2, w_b3} = i_col;

  assign w_fwd = {
    gmul2(w_b0) ^ gmul3(w_b1) ^ w_b2        ^ w_b3,
    w_b0        ^ gmul2(w_b1) ^ gmul3(w_b2) ^ w_b3,
    w_b0        ^ w_b1        ^ gmul2(w_b2) ^ gmul3(w_b3),
    gmul3(w_b0) ^ w_b1        ^ w_b2        ^ gmul2(w_b3)
  };

  assign w_inv = {
    gmul14(w_b0) ^ gmul11(w_b1) ^ gmul13(w_b2) ^ gmul9(w_b3),
    gmul9(w_b0)  ^ gmul14(w_b1) ^ gmul11(w_b2) ^ gmul13(w_b3),
    gmul13(w_b0) ^ gmul9(w_b1)  ^ gmul14(w_b2) ^ gmul11(w_b3),
    gmul11(w_b0) ^ gmul13(w_b1) ^ gmul9(w_b2)  ^ gmul14(w_b3)
  };

  assign o_col = i_decrypt ? w_inv : w_fwd;

endmodule

// File: rtl/mixcolumns_seq.sv
// rtl/mixcolumns_seq.sv - sequential MixColumns stage, one column per clock, row-format state
module mixcolumns_seq
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             decrypt,
  input  logic             bypass,
  input  logic [COL_W-1:0] line0,
  input  logic [COL_W-1:0] line1,
  input  logic [COL_W-1:0] line2,
  input  logic [COL_W-1:0] line3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] outline0,
  output logic [COL_W-1:0] outline1,
  output logic [COL_W-1:0] outline2,
  output logic [COL_W-1:0] outline3
);

  mc_state_t        r_state;
  logic [1:0]       r_col;
  logic [COL_W-1:0] r_row [N_ROWS];
  logic             r_decrypt;
  logic             r_bypass;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [4:0]       w_sh;
  logic [COL_W-1:0] w_col_in;
  logic [COL_W-1:0] w_col_mix;
  logic [COL_W-1:0] w_col_out;

  // Column c occupies bits [31-8c -: 8] of each row, i.e. LSB offset 24-8c.
  assign w_sh = 5'd24 - {r_col, 3'b000};

  always_comb begin
    w_col_in = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      w_col_in[COL_W-1-BYTE_W*r -: BYTE_W] = r_row[r][w_sh +: BYTE_W];
    end
  end

  mixcol_column u_mixcol_column (
    .i_col     (w_col_in),
    .i_decrypt (r_decrypt),
    .o_col     (w_col_mix)
  );

  assign w_col_out = r_bypass ? w_col_in : w_col_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= 2'd0;
      for (int r = 0; r < N_ROWS; r++) r_row[r] <= '0;
      r_decrypt   <= 1'b0;
      r_bypass    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_row[0]   <= line0;
            r_row[1]   <= line1;
            r_row[2]   <= line2;
            r_row[3]   <= line3;
            r_decrypt  <= decrypt;
            r_bypass   <= bypass;
            r_col      <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          for (int r = 0; r < N_ROWS; r++) begin
            r_row[r][w_sh +: BYTE_W] <= w_col_out[COL_W-1-BYTE_W*r -: BYTE_W];
          end
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign outline0  = r_row[0];
  assign outline1  = r_row[1];
  assign outline2  = r_row[2];
  assign outline3  = r_row[3];

endmodule

// File: tb/tb_mixcolumns_seq.sv
// tb/tb_mixcolumns_seq.sv - self-checking bench for mixcolumns_seq against a GF(2^8) matrix model
module tb_mixcolumns_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        decrypt;
  logic        bypass;
  logic [31:0] line0, line1, line2, line3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] outline0, outline1, outline2, outline3;

  int checks = 0;
  int errors = 0;

  mixcolumns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .decrypt   (decrypt),
    .bypass    (bypass),
    .line0     (line0),
    .line1     (line1),
    .line2     (line2),
    .line3     (line3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outline0  (outline0),
    .outline1  (outline1),
    .outline2  (outline2),
    .outline3  (outline3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  // Generic shift-and-add GF(2^8) multiply reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // State packed as {row0,row1,row2,row3}; out[r][c] = sum_k coef[(k-r) mod 4] * in[k][c].
  function automatic logic [127:0] model(input logic [127:0] s, input logic dec, input logic byp);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    if (byp) return s;
    if (dec) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gm(coef[(k - r + 4) % 4], s[127 - 32*k - 8*c -: 8]);
        o[127 - 32*r - 8*c -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {outline0, outline1, outline2, outline3};
  endfunction

  // Accept one block, optionally disturb inputs while busy, hold backpressure, then drain.
  task automatic run_block(input string tag, input logic [127:0] s, input logic dec, input logic byp,
                           input logic [127:0] exp, input int hold, input logic noisy);
    int n;
    chk({tag, " in_ready_idle"}, 128'(in_ready), 128'(1));
    {line0, line1, line2, line3} = s;
    decrypt  = dec;
    bypass   = byp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noisy;
    n = 0;
    while (!out_valid && n < 20) begin
      chk({tag, " in_ready_busy"}, 128'(in_ready), 128'(0));
      if (noisy) begin
        decrypt = ~decrypt;
        bypass  = $urandom_range(0, 1) == 1;
        {line0, line1, line2, line3} = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 128'(n), 128'(4));
    chk({tag, " result"}, outs(), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 128'(out_valid), 128'(1));
      chk({tag, " hold_data"}, outs(), exp);
      chk({tag, " hold_in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drain_valid"}, 128'(out_valid), 128'(0));
    chk({tag, " drain_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hdbf2012d_130a0126_53220131_455c014c;
  localparam logic [127:0] FIPS_OUT = 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  initial begin
    logic [127:0] s;
    logic         d, b;
    rst_n = 1'b0; in_valid = 1'b0; decrypt = 1'b0; bypass = 1'b0; out_ready = 1'b0;
    {line0, line1, line2, line3} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset outputs", outs(), 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset in_ready", 128'(in_ready), 128'(1));

    run_block("fips_fwd", FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 0, 1'b0);
    run_block("fips_inv", FIPS_OUT, 1'b1, 1'b0, FIPS_IN, 0, 1'b0);
    run_block("bypass", BYP_IN, 1'b1, 1'b1, BYP_IN, 0, 1'b0);
    run_block("backpressure", FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 10, 1'b0);
    run_block("midflight", FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 2, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_second_accept", 128'(out_valid), 128'(0));
    end

    // Reset asserted while column 2 is pending.
    {line0, line1, line2, line3} = FIPS_IN;
    decrypt = 1'b0; bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 128'(out_valid), 128'(0));
    chk("midreset in_ready", 128'(in_ready), 128'(1));
    chk("midreset outputs", outs(), 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block("post_reset", BYP_IN, 1'b0, 1'b0, model(BYP_IN, 1'b0, 1'b0), 1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      d = $urandom_range(0, 1) == 1;
      b = $urandom_range(0, 5) == 0;
      run_block("random", s, d, b, model(s, d, b), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
